// File: rtl/c64_mem_pkg.sv
// c64_mem_pkg: region encoding, window constants and map decode shared by the C64 bus stage.
package c64_mem_pkg;
    typedef enum logic [2:0] {REG_RAM, REG_BASIC, REG_KERNAL, REG_CHAR, REG_IO, REG_PORT} region_t;
    localparam logic [15:0] BASIC_BASE  = 16'hA000;
    localparam logic [15:0] KERNAL_BASE = 16'hE000;
    localparam int ROM_BITS = 13;
    localparam int IO_BITS  = 12;
    localparam int LORAM  = 0;
    localparam int HIRAM  = 1;
    localparam int CHAREN = 2;
    // io_page is the top nibble of the 4 KB I/O window base.
    function automatic region_t decode(input logic [15:0] ab, input logic [2:0] eff, input logic [3:0] io_page);
        if (ab[15:1] == 15'd0)
            return REG_PORT;
        if (ab[15:ROM_BITS] == BASIC_BASE[15:ROM_BITS])
            return (eff[LORAM] && eff[HIRAM]) ? REG_BASIC : REG_RAM;
        if (ab[15:ROM_BITS] == KERNAL_BASE[15:ROM_BITS])
            return eff[HIRAM] ? REG_KERNAL : REG_RAM;
        if (ab[15:IO_BITS] == io_page)
            return (eff[LORAM] || eff[HIRAM]) ? (eff[CHAREN] ? REG_IO : REG_CHAR) : REG_RAM;
        return REG_RAM;
    endfunction
endpackage

// File: rtl/c64_cpu_port.sv
// c64_cpu_port: 6510 on-chip port (DDR at $00, data at $01) with read-back and bank bits.
// CPU_PORT_FADE_EN makes undriven bits 7:6 hold their last driven level for FADE_CYCLES.
module c64_cpu_port import c64_mem_pkg::*; #(
    parameter logic [15:0] FADE_CYCLES = 16'd2000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_ddr,
    input  logic       wr_data,
    input  logic [7:0] wdata,
    input  logic       rd_sel,
    input  logic [7:0] port_in,
    output logic [7:0] ddr,
    output logic [7:0] pdata,
    output logic [2:0] eff,
    output logic [7:0] port_rd
);
    logic [7:0] ddr_n;
    logic [7:0] pdata_n;
    logic [7:0] pins;
    assign ddr_n   = wr_ddr ? wdata : ddr;
    assign pdata_n = wr_data ? wdata : pdata;
    always_ff @(posedge clk) begin
        if (reset) begin
            ddr   <= 8'h00;
            pdata <= 8'h00;
        end else begin
            ddr   <= ddr_n;
            pdata <= pdata_n;
        end
    end
`ifdef CPU_PORT_FADE_EN
    logic [1:0]  held;
    logic [15:0] cnt;
    logic [1:0]  load;
    // A port write while a bit is driven (including turning it to input) captures its level.
    assign load = (wr_ddr || wr_data) ? ddr[7:6] : 2'b00;
    always_ff @(posedge clk) begin
        if (reset) begin
            held <= 2'b00;
            cnt  <= 16'd0;
        end else if (|load) begin
            held <= (held & ~load) | (pdata_n[7:6] & load);
            cnt  <= FADE_CYCLES;
        end else if (cnt <= 16'd1) begin
            held <= 2'b00;
            cnt  <= 16'd0;
        end else begin
            cnt <= cnt - 16'd1;
        end
    end
    assign pins = {held, port_in[5:0]};
`else
    assign pins = port_in;
`endif
    // Undriven bank bits float high through the board pull-ups.
    assign eff     = pdata[2:0] | ~ddr[2:0];
    assign port_rd = rd_sel ? ((pdata & ddr) | (pins & ~ddr)) : ddr;
endmodule

// File: rtl/c64_mem_map.sv
// c64_mem_map: C64 memory-map decode, 6510 port and read-data steering for the 6502 core.
// Optional CPU_PORT_FADE_EN enables the bit 7:6 fade hold in the processor port.
module c64_mem_map import c64_mem_pkg::*; #(
    parameter logic [15:0] FADE_CYCLES = 16'd2000,
    parameter logic [15:0] IO_BASE     = 16'hD000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_ab,
    input  logic [7:0]  cpu_do,
    input  logic        cpu_we,
    output logic [7:0]  cpu_di,
    output logic [15:0] ram_addr,
    output logic [7:0]  ram_wdata,
    output logic        ram_we,
    input  logic [7:0]  ram_rdata,
    output logic [12:0] basic_addr,
    input  logic [7:0]  basic_data,
    output logic [12:0] kernal_addr,
    input  logic [7:0]  kernal_data,
    output logic [11:0] char_addr,
    input  logic [7:0]  char_data,
    output logic        io_cs,
    output logic        io_we,
    output logic [11:0] io_addr,
    output logic [7:0]  io_wdata,
    input  logic [7:0]  io_rdata,
    input  logic [7:0]  port_in,
    output logic [7:0]  port_out,
    output logic [7:0]  port_dir
);
    region_t    region;
    region_t    sel_q;
    logic [2:0] eff;
    logic [7:0] port_rd;
    logic [7:0] port_rd_q;
    logic       port_wr;
    c64_cpu_port #(.FADE_CYCLES(FADE_CYCLES)) u_port (
        .clk(clk),
        .reset(reset),
        .wr_ddr(port_wr && !cpu_ab[0]),
        .wr_data(port_wr && cpu_ab[0]),
        .wdata(cpu_do),
        .rd_sel(cpu_ab[0]),
        .port_in(port_in),
        .ddr(port_dir),
        .pdata(port_out),
        .eff(eff),
        .port_rd(port_rd)
    );
    assign region      = decode(cpu_ab, eff, IO_BASE[15:12]);
    assign port_wr     = cpu_we && region == REG_PORT;
    assign io_cs       = region == REG_IO;
    assign io_we       = cpu_we && io_cs;
    assign ram_we      = cpu_we && !io_cs;
    assign ram_addr    = cpu_ab;
    assign ram_wdata   = cpu_do;
    assign basic_addr  = cpu_ab[12:0];
    assign kernal_addr = cpu_ab[12:0];
    assign char_addr   = cpu_ab[11:0];
    assign io_addr     = cpu_ab[11:0];
    assign io_wdata    = cpu_do;
    // Source select and port read-back are captured before any same-edge port write lands.
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q     <= REG_RAM;
            port_rd_q <= 8'h00;
        end else begin
            sel_q     <= region;
            port_rd_q <= port_rd;
        end
    end
    assign cpu_di = sel_q == REG_BASIC  ? basic_data  :
                    sel_q == REG_KERNAL ? kernal_data :
                    sel_q == REG_CHAR   ? char_data   :
                    sel_q == REG_IO     ? io_rdata    :
                    sel_q == REG_PORT   ? port_rd_q   : ram_rdata;
endmodule
